// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-register arbiter.
// Imported by the picker and the top level.
package shared_reg_arbiter_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its encoded index.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr) + off) % NREQ;
      if (!any && req[k]) begin
        gnt[k] = 1'b1;
        idx    = IDW'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register, with bounded
// lock bursts capped at MAX_HOLD consecutive grants per owner.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | round-robin arbitration from ptr among all requesters
//   OWNED | grant reserved for owner while it keeps req+lock, up to cap
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [id_width(NREQ)-1:0] rid,
  output logic                     busy
);

  localparam int IDW = id_width(NREQ);
  localparam int HW  = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  owner;
  logic [HW-1:0]   hold_cnt;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic [IDW-1:0]  gidx;
  logic            granted;
  logic [IDW-1:0]  next_ptr;
  logic            keep_hold;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While owned, only the owner can be granted; everyone else waits.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    granted = 1'b0;
    if (state == IDLE) begin
      gnt     = pick_gnt;
      gidx    = pick_idx;
      granted = pick_any;
    end else begin
      gnt[owner] = req[owner];
      gidx       = owner;
      granted    = req[owner];
    end
  end

  assign next_ptr  = IDW'((int'(gidx) + 1) % NREQ);
  assign keep_hold = req[owner] && lock[owner] && ((int'(hold_cnt) + 1) < MAX_HOLD);
  assign busy      = (state == OWNED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      q        <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
    end else begin
      rvalid <= 1'b0;
      if (granted) begin
        if (we[gidx]) begin
          q <= wdata[int'(gidx)*WIDTH +: WIDTH];
        end else begin
          rdata  <= q;
          rvalid <= 1'b1;
          rid    <= gidx;
        end
      end

      case (state)
        IDLE: begin
          if (granted) begin
            ptr <= next_ptr;
            if (lock[gidx] && (MAX_HOLD > 1)) begin
              state    <= OWNED;
              owner    <= gidx;
              hold_cnt <= HW'(1);
            end
          end
        end
        OWNED: begin
          // ptr already points past the owner, so exit needs no ptr update.
          if (keep_hold) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: table of per-cycle vectors with
// post-edge expectations queued as a scoreboard, plus a mid-burst reset sequence.
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic [1:0]            rid;
  logic                  busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [1:0]  rid;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  shared_reg_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .lock   (lock),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rid    (rid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                              input logic [31:0] wd, input logic [3:0] g, input logic [7:0] eq,
                              input logic rv, input logic [7:0] rd, input logic [1:0] ri,
                              input logic b);
    vec_t v;
    v.req = r; v.we = w; v.lock = l; v.wdata = wd; v.gnt = g;
    v.q = eq; v.rvalid = rv; v.rdata = rd; v.rid = ri; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides of the edge.
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    req = v.req; we = v.we; lock = v.lock; wdata = v.wdata;
    #1;
    check($sformatf("gnt[%0d]", n), {28'd0, gnt}, {28'd0, v.gnt});
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("scoreboard[%0d]", n), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("q[%0d]", n), {24'd0, q}, {24'd0, e.q});
      check($sformatf("rvalid[%0d]", n), {31'd0, rvalid}, {31'd0, e.rvalid});
      check($sformatf("busy[%0d]", n), {31'd0, busy}, {31'd0, e.busy});
      if (e.rvalid) begin
        check($sformatf("rdata[%0d]", n), {24'd0, rdata}, {24'd0, e.rdata});
        check($sformatf("rid[%0d]", n), {30'd0, rid}, {30'd0, e.rid});
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; lock = '0; wdata = '0;
    #1;
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    #11 reset = 1'b0;
    @(posedge clk);
    #1;

    // idle after reset
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0));
    // fairness rotation 0,1,2,3,0
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h10, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 32'h13121110, 4'b0010, 8'h11, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 32'h13121110, 4'b0100, 8'h12, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 32'h13121110, 4'b1000, 8'h13, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h10, 1'b0, 8'h00, 2'd0, 1'b0));
    // write then read; ungranted we/wdata ignored
    vecs.push_back(mk(4'b0100, 4'b0100, 4'b0000, 32'h00A50000, 4'b0100, 8'hA5, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b1101, 4'b0000, 32'hFFFFFFFF, 4'b0010, 8'hA5, 1'b1, 8'hA5, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b1111, 32'h0,        4'b0000, 8'hA5, 1'b0, 8'h00, 2'd0, 1'b0));
    // lock cap: four grants to 0, then 1
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0011, 4'b0001, 4'b0001, 32'h00002120, 4'b0001, 8'h20, 1'b0, 8'h00, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0011, 4'b0001, 4'b0001, 32'h00002120, 4'b0001, 8'h20, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0010, 4'b0001, 32'h00002120, 4'b0010, 8'h21, 1'b0, 8'h00, 2'd0, 1'b0));
    // owner drops req while owned
    vecs.push_back(mk(4'b0100, 4'b0000, 4'b0100, 32'h0, 4'b0100, 8'h21, 1'b1, 8'h21, 2'd2, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b0000, 4'b1001, 32'h0, 4'b0000, 8'h21, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b0000, 4'b0000, 32'h0, 4'b1000, 8'h21, 1'b1, 8'h21, 2'd3, 1'b0));
    // early unlock by owner 3, then wrap to 0
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b1000, 32'h33000000, 4'b1000, 8'h33, 1'b0, 8'h00, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1000, 4'b0000, 32'h34000000, 4'b1000, 8'h34, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b0000, 4'b0000, 32'h0,        4'b0001, 8'h34, 1'b1, 8'h34, 2'd0, 1'b0));
    // start a burst for requester 1 with q=0x5A
    vecs.push_back(mk(4'b0010, 4'b0010, 4'b0010, 32'h00005A00, 4'b0010, 8'h5A, 1'b0, 8'h00, 2'd0, 1'b1));

    foreach (vecs[i]) apply(vecs[i], i);

    // asynchronous reset pulse between edges, mid-burst
    req = 4'b1001; we = 4'b0000; lock = 4'b0000; wdata = '0;
    #1 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_q", {24'd0, q}, 32'd0);
    check("arst_gnt", {28'd0, gnt}, 32'b0001);
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    #1 reset = 1'b0;

    apply(mk(4'b1001, 4'b0000, 4'b0000, 32'h0, 4'b0001, 8'h00, 1'b1, 8'h00, 2'd0, 1'b0), 100);
    apply(mk(4'b1001, 4'b0000, 4'b0000, 32'h0, 4'b1000, 8'h00, 1'b1, 8'h00, 2'd3, 1'b0), 101);

    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
